// File: rtl/univ_sseg_ctrl.sv
// rtl/univ_sseg_ctrl.sv - four-digit multiplexed seven-segment controller (hex/decimal, dual fields)
module univ_sseg_ctrl #(
    parameter int DIG_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] cnt1,
    input  logic [6:0]  cnt2,
    input  logic        valid,
    input  logic        dp_en,
    input  logic [1:0]  dp_sel,
    input  logic [1:0]  mod_sel,
    input  logic        sign,
    output logic [7:0]  ssegs,
    output logic [3:0]  disp_en
);

    localparam int CW = (DIG_CYCLES > 2) ? $clog2(DIG_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIG_CYCLES - 1);

    // Per-digit content kinds
    localparam logic [1:0] K_HEX   = 2'd0;
    localparam logic [1:0] K_BLANK = 2'd1;
    localparam logic [1:0] K_DASH  = 2'd2;
    localparam logic [1:0] K_E     = 2'd3;

    logic [CW-1:0]   cyc;
    logic [1:0]      idx;
    logic [1:0]      nxt;
    logic            tick;
    logic [19:0]     bcd1;
    logic [11:0]     bcd2;
    logic [3:0][3:0] nib;
    logic [3:0][1:0] kind;
    logic [3:0]      blk;
    logic [3:0]      cur_nib;
    logic [1:0]      cur_kind;
    logic [6:0]      seg7;
    logic            dp_n;

    // 14-bit binary to 5-digit BCD, double-dabble
    function automatic logic [19:0] bcd14(input logic [13:0] bin);
        logic [19:0] b;
        b = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int j = 0; j < 5; j++) begin
                if (b[4*j +: 4] >= 4'd5) b[4*j +: 4] = b[4*j +: 4] + 4'd3;
            end
            b = {b[18:0], bin[i]};
        end
        return b;
    endfunction

    // 7-bit binary to 3-digit BCD, double-dabble
    function automatic logic [11:0] bcd7(input logic [6:0] bin);
        logic [11:0] b;
        b = '0;
        for (int i = 6; i >= 0; i--) begin
            for (int j = 0; j < 3; j++) begin
                if (b[4*j +: 4] >= 4'd5) b[4*j +: 4] = b[4*j +: 4] + 4'd3;
            end
            b = {b[10:0], bin[i]};
        end
        return b;
    endfunction

    assign tick = (cyc == CNT_LAST);
    assign nxt  = idx + 2'd1;
    assign bcd1 = bcd14(cnt1);
    assign bcd2 = bcd7(cnt2);

    // Decide what each of the four digits shows for the current inputs
    always_comb begin
        nib  = '0;
        kind = '{default: K_HEX};
        blk  = '0;
        case (mod_sel)
            2'b00: begin
                nib = {2'b00, cnt1};
            end
            2'b01: begin
                nib = {1'b0, cnt2, cnt1[7:0]};
            end
            2'b10: begin
                if (bcd1[19:16] != 4'd0) begin
                    kind = '{default: K_E};
                end else begin
                    nib    = bcd1[15:0];
                    blk[3] = (bcd1[15:12] == 4'd0);
                    blk[2] = blk[3] && (bcd1[11:8] == 4'd0);
                    blk[1] = blk[2] && (bcd1[7:4] == 4'd0);
                    for (int i = 1; i < 4; i++) begin
                        if (blk[i]) kind[i] = K_BLANK;
                    end
                    // Minus sits on the blanked digit nearest the number
                    if (sign) begin
                        if (blk[1])      kind[1] = K_DASH;
                        else if (blk[2]) kind[2] = K_DASH;
                        else if (blk[3]) kind[3] = K_DASH;
                    end
                end
            end
            default: begin
                if (bcd2[11:8] != 4'd0) begin
                    kind[3] = K_E;
                    kind[2] = K_E;
                end else begin
                    nib[3] = bcd2[7:4];
                    nib[2] = bcd2[3:0];
                    if (bcd2[7:4] == 4'd0) kind[3] = sign ? K_DASH : K_BLANK;
                end
                if (bcd1[19:8] != 12'd0) begin
                    kind[1] = K_E;
                    kind[0] = K_E;
                end else begin
                    nib[1] = bcd1[7:4];
                    nib[0] = bcd1[3:0];
                    if (bcd1[7:4] == 4'd0) kind[1] = K_BLANK;
                end
            end
        endcase
        if (!valid) kind = '{default: K_DASH};
    end

    assign cur_nib  = nib[nxt];
    assign cur_kind = kind[nxt];
    assign dp_n     = ~(dp_en && (dp_sel == nxt));

    // Glyph lookup for the digit about to be lit, active-low {a..g}
    always_comb begin
        seg7 = 7'b1111111;
        case (cur_kind)
            K_BLANK: seg7 = 7'b1111111;
            K_DASH:  seg7 = 7'b1111110;
            K_E:     seg7 = 7'b0110000;
            default: begin
                case (cur_nib)
                    4'h0: seg7 = 7'b0000001;
                    4'h1: seg7 = 7'b1001111;
                    4'h2: seg7 = 7'b0010010;
                    4'h3: seg7 = 7'b0000110;
                    4'h4: seg7 = 7'b1001100;
                    4'h5: seg7 = 7'b0100100;
                    4'h6: seg7 = 7'b0100000;
                    4'h7: seg7 = 7'b0001111;
                    4'h8: seg7 = 7'b0000000;
                    4'h9: seg7 = 7'b0000100;
                    4'hA: seg7 = 7'b0001000;
                    4'hB: seg7 = 7'b1100000;
                    4'hC: seg7 = 7'b0110001;
                    4'hD: seg7 = 7'b1000010;
                    4'hE: seg7 = 7'b0110000;
                    default: seg7 = 7'b0111000;
                endcase
            end
        endcase
    end

    // Free-running dwell counter and digit scan index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= '0;
            idx <= 2'd3;
        end else if (tick) begin
            cyc <= '0;
            idx <= nxt;
        end else begin
            cyc <= cyc + 1'b1;
        end
    end

    // Register cathodes and anodes for the newly selected digit on each tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssegs   <= 8'hFF;
            disp_en <= 4'hF;
        end else if (tick) begin
            ssegs   <= {seg7, dp_n};
            disp_en <= ~(4'b0001 << nxt);
        end
    end

endmodule

// File: tb/tb_univ_sseg_ctrl.sv
// tb/tb_univ_sseg_ctrl.sv - scoreboard bench for univ_sseg_ctrl
module tb_univ_sseg_ctrl;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] cnt1 = '0;
    logic [6:0]  cnt2 = '0;
    logic        valid = 1'b1;
    logic        dp_en = 1'b0;
    logic [1:0]  dp_sel = '0;
    logic [1:0]  mod_sel = '0;
    logic        sign = 1'b0;
    logic [7:0]  ssegs;
    logic [3:0]  disp_en;

    univ_sseg_ctrl #(.DIG_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .cnt1(cnt1), .cnt2(cnt2), .valid(valid),
        .dp_en(dp_en), .dp_sel(dp_sel), .mod_sel(mod_sel), .sign(sign),
        .ssegs(ssegs), .disp_en(disp_en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    typedef struct packed {
        logic            v;
        logic [1:0]      m;
        logic [13:0]     c1;
        logic [6:0]      c2;
        logic            s;
        logic            de;
        logic [1:0]      ds;
        logic [3:0][7:0] e;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[13];
    logic [3:0] an_tab[4];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cur;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic apply(input vec_t t);
        int d;
        valid   = t.v;
        mod_sel = t.m;
        cnt1    = t.c1;
        cnt2    = t.c2;
        sign    = t.s;
        dp_en   = t.de;
        dp_sel  = t.ds;
        for (int k = 1; k <= 4; k++) begin
            d = (cur + k) % 4;
            sb.push_back({an_tab[d], t.e[d]});
        end
    endtask

    task automatic tick_check(input int edges, input string tag);
        exp_t x;
        repeat (edges) @(posedge clk);
        #1;
        cur = (cur + 1) % 4;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            check({tag, "_anode"}, {28'd0, disp_en}, {28'd0, x.an});
            check({tag, "_seg"}, {24'd0, ssegs}, {24'd0, x.seg});
        end
    endtask

    initial begin
        an_tab[0] = 4'b1110;
        an_tab[1] = 4'b1101;
        an_tab[2] = 4'b1011;
        an_tab[3] = 4'b0111;
        //            v     mode   cnt1          cnt2    s     dpe   dps    digits 3..0
        vecs[0]  = '{1'b1, 2'b10, 14'd9999,     7'd0,   1'b0, 1'b0, 2'd0, {8'h09, 8'h09, 8'h09, 8'h09}};
        vecs[1]  = '{1'b1, 2'b10, 14'd2,        7'd0,   1'b0, 1'b0, 2'd0, {8'hFF, 8'hFF, 8'hFF, 8'h25}};
        vecs[2]  = '{1'b1, 2'b10, 14'd10000,    7'd0,   1'b0, 1'b0, 2'd0, {8'h61, 8'h61, 8'h61, 8'h61}};
        vecs[3]  = '{1'b1, 2'b10, 14'd42,       7'd0,   1'b1, 1'b0, 2'd0, {8'hFF, 8'hFD, 8'h99, 8'h25}};
        vecs[4]  = '{1'b1, 2'b10, 14'd1234,     7'd0,   1'b1, 1'b0, 2'd0, {8'h9F, 8'h25, 8'h0D, 8'h99}};
        vecs[5]  = '{1'b1, 2'b00, 14'h2A5F,     7'd0,   1'b0, 1'b0, 2'd0, {8'h25, 8'h11, 8'h49, 8'h71}};
        vecs[6]  = '{1'b1, 2'b11, 14'd58,       7'd7,   1'b0, 1'b0, 2'd0, {8'hFF, 8'h1F, 8'h49, 8'h01}};
        vecs[7]  = '{1'b0, 2'b10, 14'd1234,     7'd0,   1'b0, 1'b1, 2'd2, {8'hFD, 8'hFC, 8'hFD, 8'hFD}};
        vecs[8]  = '{1'b1, 2'b01, 14'h03A7,     7'h5C,  1'b0, 1'b0, 2'd0, {8'h49, 8'h63, 8'h11, 8'h1F}};
        vecs[9]  = '{1'b1, 2'b11, 14'd5,        7'd120, 1'b1, 1'b1, 2'd0, {8'h61, 8'h61, 8'hFF, 8'h48}};
        vecs[10] = '{1'b1, 2'b11, 14'd100,      7'd3,   1'b1, 1'b0, 2'd0, {8'hFD, 8'h0D, 8'h61, 8'h61}};
        vecs[11] = '{1'b1, 2'b10, 14'd5,        7'd0,   1'b1, 1'b0, 2'd0, {8'hFF, 8'hFF, 8'hFD, 8'h49}};
        vecs[12] = '{1'b1, 2'b10, 14'd0,        7'd0,   1'b0, 1'b1, 2'd3, {8'hFE, 8'hFF, 8'hFF, 8'h03}};

        repeat (2) @(posedge clk);
        #1;
        check("rst_seg", {24'd0, ssegs}, 32'hFF);
        check("rst_an", {28'd0, disp_en}, 32'hF);

        @(negedge clk);
        rst_n = 1'b1;
        cur = 3;
        apply(vecs[0]);
        for (int k = 0; k < DC - 1; k++) begin
            @(posedge clk);
            #1;
            check("pre_tick_seg", {24'd0, ssegs}, 32'hFF);
            check("pre_tick_an", {28'd0, disp_en}, 32'hF);
        end
        tick_check(1, "v0");
        for (int k = 0; k < 3; k++) tick_check(DC, "v0");

        for (int v = 1; v < 13; v++) begin
            apply(vecs[v]);
            for (int k = 0; k < 4; k++) tick_check(DC, $sformatf("v%0d", v));
        end

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_seg", {24'd0, ssegs}, 32'hFF);
        check("async_rst_an", {28'd0, disp_en}, 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        cur = 3;
        apply(vecs[5]);
        for (int k = 0; k < 4; k++) tick_check(DC, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
